// File: rtl/div_pkg.sv
// div_pkg: widths and FSM encoding shared by the divider and the multiplier.
package div_pkg;
    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} divState_t;
endpackage

// File: rtl/div_step.sv
// div_step: one radix-2 restoring iteration on the {R,Q} pair.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   rNext,
    output logic [WIDTH-1:0] qNext
);
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;
    // R < D always holds, so the extra top bit of the shift never carries data and acts as the sign slot
    always_comb begin
        shifted = {r, q[WIDTH-1]};
        trial = shifted - {2'b0, d};
        rNext = trial[WIDTH+1] ? shifted[WIDTH:0] : trial[WIDTH:0];
        qNext = {q[WIDTH-2:0], ~trial[WIDTH+1]};
    end
endmodule

// File: rtl/div_unsigned.sv
// div_unsigned: multi-cycle restoring divider, quotient on LO and remainder on HI.
module div_unsigned
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotientLO,
    output logic [WIDTH-1:0] remainderHI,
    output logic             div_zero
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
    divState_t state, nextState;
    logic [WIDTH:0] r, rNext;
    logic [WIDTH-1:0] q, qNext, d;
    logic [CNT_W-1:0] count;
    logic accept, lastStep;
    div_step #(.WIDTH(WIDTH)) step (
        .r(r),
        .q(q),
        .d(d),
        .rNext(rNext),
        .qNext(qNext)
    );
    assign busy = state != IDLE;
    assign done = state == DONE;
    always_comb begin
        accept = state == IDLE && start;
        lastStep = state == RUN && count == LAST;
        nextState = accept ? (divisor == '0 ? DONE : RUN) : lastStep ? DONE : state == DONE ? IDLE : state;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= nextState;
    end
    // results are loaded on entry to DONE so they are already valid while done is high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r <= '0;
            q <= '0;
            d <= '0;
            count <= '0;
            quotientLO <= '0;
            remainderHI <= '0;
            div_zero <= 1'b0;
        end else if (accept) begin
            r <= '0;
            q <= dividend;
            d <= divisor;
            count <= '0;
            if (divisor == '0) begin
                quotientLO <= '1;
                remainderHI <= dividend;
                div_zero <= 1'b1;
            end
        end else if (state == RUN) begin
            r <= rNext;
            q <= qNext;
            count <= count + 1'b1;
            if (lastStep) begin
                quotientLO <= qNext;
                remainderHI <= rNext[WIDTH-1:0];
                div_zero <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_div_unsigned.sv
// tb_div_unsigned: scoreboard bench comparing the divider against plain / and % arithmetic.
module tb_div_unsigned;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic busy, done, div_zero;
    logic [31:0] quotientLO, remainderHI;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int cyc = 0;
    int vectors = 0;
    int fails = 0;
    logic [31:0] heldQ = '0, heldR = '0;
    logic heldZ = 1'b0;

    div_unsigned #(.WIDTH(32)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .quotientLO(quotientLO),
        .remainderHI(remainderHI),
        .div_zero(div_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int acc);
        exp_t e;
        e.acc = acc;
        if (b == 0) begin
            e.q = '1;
            e.r = a;
            e.dz = 1'b1;
            e.lat = 1;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.dz = 1'b0;
            e.lat = 33;
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic runOp(input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            vectors++;
            fails++;
            $display("FAIL idle-wait: busy still 1 expected 0 after %0d cycles", n);
            return;
        end
        dividend = a;
        divisor = b;
        start = 1'b1;
        sb.push_back(model(a, b, cyc + 1));
        @(negedge clk);
        start = 1'b0;
    endtask

    // monitor: one sample per cycle, just after the active edge
    always begin
        exp_t e;
        logic expBusy;
        @(posedge clk);
        #1;
        if (!reset_n) begin
            heldQ = '0;
            heldR = '0;
            heldZ = 1'b0;
        end else begin
            expBusy = sb.size() > 0 && cyc >= sb[0].acc;
            check("busy", {31'b0, busy}, {31'b0, expBusy});
            if (done) begin
                if (sb.size() == 0) begin
                    vectors++;
                    fails++;
                    $display("FAIL unexpected-done: done=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    check("quotientLO", quotientLO, e.q);
                    check("remainderHI", remainderHI, e.r);
                    check("div_zero", {31'b0, div_zero}, {31'b0, e.dz});
                    check("latency", cyc - e.acc + 1, e.lat);
                    heldQ = e.q;
                    heldR = e.r;
                    heldZ = e.dz;
                end
            end else begin
                check("held-quotient", quotientLO, heldQ);
                check("held-remainder", remainderHI, heldR);
                check("held-divzero", {31'b0, div_zero}, {31'b0, heldZ});
            end
        end
    end

    initial begin
        logic [31:0] a, b;
        int n;
        repeat (2) @(negedge clk);
        check("reset-busy", {31'b0, busy}, 32'd0);
        check("reset-done", {31'b0, done}, 32'd0);
        check("reset-quotient", quotientLO, 32'd0);
        check("reset-remainder", remainderHI, 32'd0);
        check("reset-divzero", {31'b0, div_zero}, 32'd0);
        reset_n = 1'b1;
        runOp(32'd176, 32'd27);
        runOp(32'hFFFF_FFFF, 32'd1);
        runOp(32'd7, 32'd9);
        runOp(32'd100, 32'd0);
        runOp(32'd0, 32'd5);
        runOp(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        runOp(32'h8000_0000, 32'd3);
        // a start raised mid-operation must be ignored
        runOp(32'd176, 32'd27);
        repeat (9) @(negedge clk);
        dividend = 32'd50;
        divisor = 32'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // reset in the middle of an operation drops it
        runOp(32'd12345, 32'd11);
        repeat (14) @(negedge clk);
        reset_n = 1'b0;
        sb.delete();
        #1;
        check("midreset-busy", {31'b0, busy}, 32'd0);
        check("midreset-done", {31'b0, done}, 32'd0);
        check("midreset-quotient", quotientLO, 32'd0);
        check("midreset-remainder", remainderHI, 32'd0);
        check("midreset-divzero", {31'b0, div_zero}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        runOp(32'd1000, 32'd7);
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = $urandom_range(1, 255);
                2: b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            runOp(a, b);
        end
        n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            vectors++;
            fails++;
            $display("FAIL drain: %0d results outstanding expected 0", sb.size());
        end
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
